// File: rtl/cap_touch_scanner_pkg.sv
// Shared definitions for the capacitive pad scanner: FSM encoding and default timing constants.
package cap_touch_scanner_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CHARGE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_EVAL    = 2'd3
   } scan_state_t;

   localparam int N_SENSORS_DEF      = 9;
   localparam int CNT_W_DEF          = 10;
   localparam int CHARGE_CYCLES_DEF  = 64;
   localparam int TIMEOUT_CYCLES_DEF = 1000;
   localparam int THRESHOLD_DEF      = 200;
   localparam int DEBOUNCE_DEF       = 4;

endpackage

// File: rtl/cap_touch_scanner_pad_channel.sv
// One capacitive pad: input synchronizer, latch-on-fall discharge count, threshold,
// debounce and the sticky hit flag.
module cap_pad_channel
   import cap_touch_scanner_pkg::*;
#(
   parameter int CNT_W          = CNT_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int THRESHOLD      = THRESHOLD_DEF,
   parameter int DEBOUNCE       = DEBOUNCE_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pad_in,
   input  logic             measure,
   input  logic             commit,
   input  logic             eval,
   input  logic [CNT_W-1:0] timer,
   input  logic             clear,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             touch,
   output logic             hit
);

   localparam int               DB_W        = $clog2(DEBOUNCE + 1);
   localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] THRESH     = CNT_W'(THRESHOLD);

   logic             sync_a, sync_b;
   logic             latched;
   logic [CNT_W-1:0] work_cnt;
   logic [CNT_W-1:0] last_cnt;
   logic [DB_W-1:0]  db_cnt;
   logic             raw;
   logic             rise;

   // A pad counts as finished once it has latched or is seen low right now.
   assign done  = latched | ~sync_b;
   assign raw   = last_cnt > THRESH;
   assign rise  = eval && raw && !touch && (db_cnt == DB_LAST);
   assign count = last_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_a   <= 1'b0;
         sync_b   <= 1'b0;
         latched  <= 1'b0;
         work_cnt <= '0;
         last_cnt <= '0;
         db_cnt   <= '0;
         touch    <= 1'b0;
         hit      <= 1'b0;
      end else begin
         sync_a <= pad_in;
         sync_b <= sync_a;

         if (!measure) begin
            latched <= 1'b0;
         end else if (!latched && !sync_b) begin
            latched  <= 1'b1;
            work_cnt <= timer;
         end

         // Only a completed scan replaces the visible count; aborted scans never commit.
         if (commit)
            last_cnt <= latched ? work_cnt : (!sync_b ? timer : TIMEOUT_VAL);

         if (eval) begin
            if (raw == touch) begin
               db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
               db_cnt <= '0;
               touch  <= raw;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end

         if (rise)
            hit <= 1'b1;
         else if (clear)
            hit <= 1'b0;
      end
   end

endmodule

// File: rtl/cap_touch_scanner.sv
// Capacitive pad scanner: charge/measure/evaluate sequencer, shared measure timer,
// per-pad channels and the debug count mux.
module cap_touch_scanner
   import cap_touch_scanner_pkg::*;
#(
   parameter int N_SENSORS      = N_SENSORS_DEF,
   parameter int CNT_W          = CNT_W_DEF,
   parameter int CHARGE_CYCLES  = CHARGE_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int THRESHOLD      = THRESHOLD_DEF,
   parameter int DEBOUNCE       = DEBOUNCE_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [N_SENSORS-1:0] capacitive_sensors_in,
   output logic                 capacitive_sensors_out,
   input  logic                 clear_valid,
   input  logic [N_SENSORS-1:0] clear_mask,
   output logic [N_SENSORS-1:0] touch_state,
   output logic [N_SENSORS-1:0] hit_flags,
   output logic                 scan_done,
   input  logic [3:0]           dbg_sel,
   output logic [CNT_W-1:0]     dbg_count
);

   localparam int               SEL_W        = 4;
   localparam int               CC_W         = $clog2(CHARGE_CYCLES + 1);
   localparam logic [CC_W-1:0]  CHARGE_LAST  = CC_W'(CHARGE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   scan_state_t          state;
   logic [CC_W-1:0]      charge_cnt;
   logic [CNT_W-1:0]     timer;
   logic [N_SENSORS-1:0] done;
   logic                 all_done;
   logic                 measure;
   logic                 eval;
   logic                 commit;
   logic [CNT_W-1:0]     counts [N_SENSORS];

   assign all_done = &done;
   assign measure  = (state == ST_MEASURE);
   assign eval     = (state == ST_EVAL);
   // MEASURE spans at most TIMEOUT_CYCLES cycles; pads still high on the last one saturate.
   assign commit   = measure && enable && (all_done || timer == TIMEOUT_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state                  <= ST_IDLE;
         capacitive_sensors_out <= 1'b0;
         scan_done              <= 1'b0;
         charge_cnt             <= '0;
         timer                  <= '0;
      end else begin
         scan_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               capacitive_sensors_out <= 1'b0;
               if (enable) begin
                  state                  <= ST_CHARGE;
                  capacitive_sensors_out <= 1'b1;
                  charge_cnt             <= '0;
               end
            end
            ST_CHARGE: begin
               if (!enable) begin
                  state                  <= ST_IDLE;
                  capacitive_sensors_out <= 1'b0;
               end else if (charge_cnt == CHARGE_LAST) begin
                  state                  <= ST_MEASURE;
                  capacitive_sensors_out <= 1'b0;
                  timer                  <= '0;
               end else begin
                  charge_cnt <= charge_cnt + 1'b1;
               end
            end
            ST_MEASURE: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (commit) begin
                  state     <= ST_EVAL;
                  scan_done <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_EVAL: begin
               if (enable) begin
                  state                  <= ST_CHARGE;
                  capacitive_sensors_out <= 1'b1;
                  charge_cnt             <= '0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state                  <= ST_IDLE;
               capacitive_sensors_out <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < N_SENSORS; g++) begin : g_pad
      cap_pad_channel #(
         .CNT_W          (CNT_W),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
         .THRESHOLD      (THRESHOLD),
         .DEBOUNCE       (DEBOUNCE)
      ) u_pad (
         .clock   (clock),
         .reset   (reset),
         .pad_in  (capacitive_sensors_in[g]),
         .measure (measure),
         .commit  (commit),
         .eval    (eval),
         .timer   (timer),
         .clear   (clear_valid & clear_mask[g]),
         .done    (done[g]),
         .count   (counts[g]),
         .touch   (touch_state[g]),
         .hit     (hit_flags[g])
      );
   end

   always_comb begin
      dbg_count = '0;
      for (int i = 0; i < N_SENSORS; i++)
         if (dbg_sel == SEL_W'(i))
            dbg_count = counts[i];
   end

endmodule

// File: tb/tb_cap_touch_scanner.sv
// Directed bench for cap_touch_scanner: a pad model releases each pad a programmed number
// of cycles after the charge drive drops, and each task checks its scenario inline.
module tb_cap_touch_scanner;
   import cap_touch_scanner_pkg::*;

   logic       clock;
   logic       reset;
   logic       enable;
   logic [8:0] pads;
   logic       capacitive_sensors_out;
   logic       clear_valid;
   logic [8:0] clear_mask;
   logic [8:0] touch_state;
   logic [8:0] hit_flags;
   logic       scan_done;
   logic [3:0] dbg_sel;
   logic [9:0] dbg_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int mcyc  = 0;
   int dly [9];

   cap_touch_scanner dut (
      .clock                  (clock),
      .reset                  (reset),
      .enable                 (enable),
      .capacitive_sensors_in  (pads),
      .capacitive_sensors_out (capacitive_sensors_out),
      .clear_valid            (clear_valid),
      .clear_mask             (clear_mask),
      .touch_state            (touch_state),
      .hit_flags              (hit_flags),
      .scan_done              (scan_done),
      .dbg_sel                (dbg_sel),
      .dbg_count              (dbg_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   // Pads sit high while charged, then each falls dly[i] cycles after the drive drops.
   always @(posedge clock) begin
      #1;
      if (capacitive_sensors_out) begin
         mcyc = 0;
         pads = 9'h1FF;
      end else begin
         for (int i = 0; i < 9; i++) pads[i] = (mcyc < dly[i]);
         mcyc++;
      end
   end

   task automatic wait_scan(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(posedge clock); #1;
         if (scan_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic settle;
      @(posedge clock); #1;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clock);
      #1;
      total++; if (capacitive_sensors_out !== 1'b0) begin bad++; $display("FAIL rst_out got=%b want=0", capacitive_sensors_out); end
      total++; if (scan_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", scan_done); end
      total++; if (touch_state !== 9'h000) begin bad++; $display("FAIL rst_touch got=%h want=000", touch_state); end
      total++; if (hit_flags !== 9'h000) begin bad++; $display("FAIL rst_hit got=%h want=000", hit_flags); end
      total++; if (dbg_count !== 10'd0) begin bad++; $display("FAIL rst_dbg got=%0d want=0", dbg_count); end
      reset  = 1'b1;
      enable = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      total++; if (capacitive_sensors_out !== 1'b1) begin bad++; $display("FAIL charge_out got=%b want=1", capacitive_sensors_out); end
      #2 reset = 1'b0;
      #1;
      total++; if (capacitive_sensors_out !== 1'b0) begin bad++; $display("FAIL async_rst_out got=%b want=0", capacitive_sensors_out); end
      total++; if (touch_state !== 9'h000 || hit_flags !== 9'h000 || scan_done !== 1'b0) begin
         bad++; $display("FAIL async_rst_outs got=%h/%h/%b want=000/000/0", touch_state, hit_flags, scan_done);
      end
      enable = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      total++; if (capacitive_sensors_out !== 1'b0) begin bad++; $display("FAIL idle_out got=%b want=0", capacitive_sensors_out); end
      enable = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      total++; if (capacitive_sensors_out !== 1'b1) begin bad++; $display("FAIL restart_out got=%b want=1", capacitive_sensors_out); end
   endtask

   task automatic test_basic_scan;
      bit ok;
      int c1;
      wait_scan(ok);
      total++; if (!ok) begin bad++; $display("FAIL basic_scan1 got=timeout want=scan_done"); end
      c1 = cyc;
      dbg_sel = 4'd0;
      #1;
      total++; if (dbg_count !== 10'd52) begin bad++; $display("FAIL basic_cnt0 got=%0d want=52", dbg_count); end
      dbg_sel = 4'd8;
      #1;
      total++; if (dbg_count !== 10'd52) begin bad++; $display("FAIL basic_cnt8 got=%0d want=52", dbg_count); end
      wait_scan(ok);
      total++; if (!ok || (cyc - c1) != 118) begin bad++; $display("FAIL basic_period got=%0d want=118", cyc - c1); end
      settle();
      total++; if (touch_state !== 9'h000) begin bad++; $display("FAIL basic_touch got=%h want=000", touch_state); end
      total++; if (hit_flags !== 9'h000) begin bad++; $display("FAIL basic_hit got=%h want=000", hit_flags); end
   endtask

   task automatic test_debounce;
      bit ok;
      dly[3] = 298;
      for (int s = 0; s < 3; s++) begin
         wait_scan(ok);
         total++; if (!ok) begin bad++; $display("FAIL deb_a_scan%0d got=timeout want=scan_done", s); end
         settle();
      end
      dbg_sel = 4'd3;
      #1;
      total++; if (dbg_count !== 10'd300) begin bad++; $display("FAIL deb_cnt3 got=%0d want=300", dbg_count); end
      total++; if (touch_state !== 9'h000) begin bad++; $display("FAIL deb_three got=%h want=000", touch_state); end
      dly[3] = 50;
      wait_scan(ok); settle();
      total++; if (!ok || touch_state !== 9'h000) begin bad++; $display("FAIL deb_break got=%h want=000", touch_state); end
      dly[3] = 298;
      for (int s = 1; s <= 4; s++) begin
         wait_scan(ok); settle();
         if (s == 1 || s == 3) begin
            total++; if (!ok || touch_state !== 9'h000) begin bad++; $display("FAIL deb_b%0d got=%h want=000", s, touch_state); end
         end
      end
      total++; if (touch_state !== 9'h008) begin bad++; $display("FAIL deb_touch got=%h want=008", touch_state); end
      total++; if (hit_flags !== 9'h008) begin bad++; $display("FAIL deb_hit got=%h want=008", hit_flags); end
   endtask

   task automatic test_clear;
      bit ok;
      clear_mask = 9'h008; clear_valid = 1'b1;
      @(posedge clock); #1;
      clear_valid = 1'b0;
      total++; if (hit_flags !== 9'h000) begin bad++; $display("FAIL clr_steady got=%h want=000", hit_flags); end
      total++; if (touch_state !== 9'h008) begin bad++; $display("FAIL clr_touch_held got=%h want=008", touch_state); end
      clear_mask = 9'h1FF; clear_valid = 1'b1;
      @(posedge clock); #1;
      clear_valid = 1'b0;
      total++; if (hit_flags !== 9'h000) begin bad++; $display("FAIL clr_all_nohit got=%h want=000", hit_flags); end
      dly[3] = 50;
      for (int s = 0; s < 4; s++) begin wait_scan(ok); settle(); end
      total++; if (touch_state !== 9'h000 || hit_flags !== 9'h000) begin
         bad++; $display("FAIL clr_release got=%h/%h want=000/000", touch_state, hit_flags);
      end
      dly[3] = 298;
      for (int s = 0; s < 3; s++) begin wait_scan(ok); settle(); end
      wait_scan(ok);
      total++; if (!ok) begin bad++; $display("FAIL clr_rise_scan got=timeout want=scan_done"); end
      clear_mask = 9'h008; clear_valid = 1'b1;
      @(posedge clock); #1;
      clear_valid = 1'b0;
      total++; if (touch_state !== 9'h008) begin bad++; $display("FAIL clr_rise_touch got=%h want=008", touch_state); end
      total++; if (hit_flags !== 9'h008) begin bad++; $display("FAIL clr_set_wins got=%h want=008", hit_flags); end
      clear_valid = 1'b1;
      @(posedge clock); #1;
      clear_valid = 1'b0;
      total++; if (hit_flags !== 9'h000) begin bad++; $display("FAIL clr_second got=%h want=000", hit_flags); end
   endtask

   task automatic test_timeout;
      bit ok;
      int c1;
      dly[3] = 50;
      dly[8] = 5000;
      wait_scan(ok);
      c1 = cyc;
      dbg_sel = 4'd8;
      #1;
      total++; if (!ok || dbg_count !== 10'd1000) begin bad++; $display("FAIL to_cnt8 got=%0d want=1000", dbg_count); end
      wait_scan(ok);
      total++; if (!ok || (cyc - c1) != 1065) begin bad++; $display("FAIL to_period got=%0d want=1065", cyc - c1); end
      wait_scan(ok); wait_scan(ok); settle();
      total++; if (touch_state !== 9'h100) begin bad++; $display("FAIL to_touch got=%h want=100", touch_state); end
      total++; if (hit_flags !== 9'h100) begin bad++; $display("FAIL to_hit got=%h want=100", hit_flags); end
   endtask

   task automatic test_threshold;
      bit ok;
      dly[8] = 50;
      dly[0] = 198;
      dly[1] = 199;
      wait_scan(ok);
      dbg_sel = 4'd0;
      #1;
      total++; if (!ok || dbg_count !== 10'd200) begin bad++; $display("FAIL th_cnt0 got=%0d want=200", dbg_count); end
      dbg_sel = 4'd1;
      #1;
      total++; if (dbg_count !== 10'd201) begin bad++; $display("FAIL th_cnt1 got=%0d want=201", dbg_count); end
      dbg_sel = 4'd9;
      #1;
      total++; if (dbg_count !== 10'd0) begin bad++; $display("FAIL th_sel9 got=%0d want=0", dbg_count); end
      dbg_sel = 4'd15;
      #1;
      total++; if (dbg_count !== 10'd0) begin bad++; $display("FAIL th_sel15 got=%0d want=0", dbg_count); end
      for (int s = 0; s < 3; s++) wait_scan(ok);
      settle();
      total++; if (touch_state !== 9'h002) begin bad++; $display("FAIL th_touch got=%h want=002", touch_state); end
      total++; if (hit_flags !== 9'h102) begin bad++; $display("FAIL th_hit got=%h want=102", hit_flags); end
   endtask

   task automatic test_abort;
      bit ok;
      int seen;
      dbg_sel = 4'd1;
      dly[1]  = 400;
      repeat (164) @(posedge clock);
      #1;
      enable = 1'b0;
      seen = 0;
      settle();
      total++; if (capacitive_sensors_out !== 1'b0) begin bad++; $display("FAIL ab_out got=%b want=0", capacitive_sensors_out); end
      for (int k = 0; k < 600; k++) begin
         @(posedge clock); #1;
         if (scan_done === 1'b1) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL ab_no_done got=%0d want=0", seen); end
      total++; if (dbg_count !== 10'd201) begin bad++; $display("FAIL ab_dbg_kept got=%0d want=201", dbg_count); end
      total++; if (touch_state !== 9'h002 || hit_flags !== 9'h102) begin
         bad++; $display("FAIL ab_held got=%h/%h want=002/102", touch_state, hit_flags);
      end
      enable = 1'b1;
      wait_scan(ok);
      total++; if (!ok || dbg_count !== 10'd402) begin bad++; $display("FAIL ab_resume got=%0d want=402", dbg_count); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=time_limit want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b0;
      enable      = 1'b0;
      clear_valid = 1'b0;
      clear_mask  = 9'h000;
      dbg_sel     = 4'd0;
      pads        = 9'h000;
      for (int i = 0; i < 9; i++) dly[i] = 50;
      test_reset();
      test_basic_scan();
      test_debounce();
      test_clear();
      test_timeout();
      test_threshold();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
